ppa_arbiter: RTL and testbench

Shares one 16-bit Kogge-Stone prefix adder (`ppa`) among NREQ requesters. Each requester has its own valid/ready operand port. A round-robin arbiter grants one requester per cycle. Operands pass through a two-stage pipeline (operand register, then result register), and results leave on a single valid/ready response port tagged with the requester index. The block sits between the requesting datapath units and the shared adder instance.

---
 rtl/ppa_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ppa_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppa_arbiter.sv
// Round-robin front end that shares one 16-bit Kogge-Stone prefix adder among
// NREQ requesters through a two-stage operand/result pipeline.

module ppa (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] s_o,
  output logic        co_o
);

  logic [15:0] g0, p0, g1, p1, g2, p2, g3, p3, g4;

  assign g0 = a_i & b_i;
  assign p0 = a_i ^ b_i;

  // Each level doubles the span of every (g,p) group. Zeros are shifted in
  // below bit 0 because there is no carry-in.
  assign g1 = g0 | (p0 & {g0[14:0], 1'b0});
  assign p1 = p0 & {p0[14:0], 1'b0};
  assign g2 = g1 | (p1 & {g1[13:0], 2'b0});
  assign p2 = p1 & {p1[13:0], 2'b0};
  assign g3 = g2 | (p2 & {g2[11:0], 4'b0});
  assign p3 = p2 & {p2[11:0], 4'b0};
  assign g4 = g3 | (p3 & {g3[7:0], 8'b0});

  assign s_o  = p0 ^ {g4[14:0], 1'b0};
  assign co_o = g4[15];

endmodule

module ppa_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_sum,
  output logic                 rsp_co,
  output logic [15:0]          done_cnt
);

  localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1Valid_q, s1Valid_d;
  logic [15:0]    s1A_q, s1A_d, s1B_q, s1B_d;
  logic [IDW-1:0] s1Id_q, s1Id_d;
  logic           rspValid_q, rspValid_d;
  logic [15:0]    rspSum_q, rspSum_d;
  logic           rspCo_q, rspCo_d;
  logic [IDW-1:0] rspId_q, rspId_d;
  logic [15:0]    doneCnt_q, doneCnt_d;

  logic [15:0]     reqAArr [NREQ];
  logic [15:0]     reqBArr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grantIdx;
  logic            found;
  logic [IDW:0]    idx;
  logic            s2Free, s1Free, accept;
  logic [15:0]     addSum;
  logic            addCo;

  for (genvar i = 0; i < NREQ; i++) begin : gUnpack
    assign reqAArr[i] = req_a[16*i +: 16];
    assign reqBArr[i] = req_b[16*i +: 16];
  end

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found           = 1'b1;
        grantIdx        = idx[IDW-1:0];
        grant[idx[IDW-1:0]] = 1'b1;
      end
    end
  end

  assign s2Free    = !rspValid_q || rsp_ready;
  assign s1Free    = !s1Valid_q || s2Free;
  assign req_ready = grant & {NREQ{s1Free && !rst}};
  assign accept    = found && s1Free && !rst;

  ppa uPpa (
    .a_i  (s1A_q),
    .b_i  (s1B_q),
    .s_o  (addSum),
    .co_o (addCo)
  );

  always_comb begin
    ptr_d      = ptr_q;
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1Id_d     = s1Id_q;
    rspValid_d = rspValid_q;
    rspSum_d   = rspSum_q;
    rspCo_d    = rspCo_q;
    rspId_d    = rspId_q;
    doneCnt_d  = doneCnt_q;

    if (accept) begin
      s1Valid_d = 1'b1;
      s1A_d     = reqAArr[grantIdx];
      s1B_d     = reqBArr[grantIdx];
      s1Id_d    = grantIdx;
      ptr_d     = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + IDW'(1);
    end else if (s2Free) begin
      s1Valid_d = 1'b0;
    end

    // An empty stage 1 advancing into a free stage 2 creates a bubble; the
    // old result fields are left untouched.
    if (s2Free) begin
      rspValid_d = s1Valid_q;
      if (s1Valid_q) begin
        rspSum_d = addSum;
        rspCo_d  = addCo;
        rspId_d  = s1Id_q;
      end
    end

    if (rspValid_q && rsp_ready) begin
      doneCnt_d = doneCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      s1Valid_q  <= 1'b0;
      s1A_q      <= '0;
      s1B_q      <= '0;
      s1Id_q     <= '0;
      rspValid_q <= 1'b0;
      rspSum_q   <= '0;
      rspCo_q    <= 1'b0;
      rspId_q    <= '0;
      doneCnt_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1Valid_q  <= s1Valid_d;
      s1A_q      <= s1A_d;
      s1B_q      <= s1B_d;
      s1Id_q     <= s1Id_d;
      rspValid_q <= rspValid_d;
      rspSum_q   <= rspSum_d;
      rspCo_q    <= rspCo_d;
      rspId_q    <= rspId_d;
      doneCnt_q  <= doneCnt_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_id    = rspId_q;
  assign rsp_sum   = rspSum_q;
  assign rsp_co    = rspCo_q;
  assign done_cnt  = doneCnt_q;

endmodule

// File: tb/tb_ppa_arbiter.sv
// Self-checking bench for ppa_arbiter: directed vector table, hand-written
// multi-cycle sequences and a random soak against a transaction-level model.

module tb_ppa_arbiter;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   reqValid;
  logic [NREQ-1:0]   reqReady;
  logic [16*NREQ-1:0] reqA;
  logic [16*NREQ-1:0] reqB;
  logic              rspValid;
  logic              rspReady;
  logic [1:0]        rspId;
  logic [15:0]       rspSum;
  logic              rspCo;
  logic [15:0]       doneCnt;

  ppa_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_sum   (rspSum),
    .rsp_co    (rspCo),
    .done_cnt  (doneCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [16:0] res;
    int          acceptEdge;
  } entry_t;

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  logic [15:0] opA [NREQ];
  logic [15:0] opB [NREQ];
  entry_t      sbQ [$];
  int          modelPtr;
  logic [15:0] modelDone;
  int          edgeCount;
  int          testsRun;
  int          testsFailed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int firstValid(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Drive one cycle's inputs just after the falling edge; the window before
  // the next rising edge is where everything is sampled.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr, input logic r);
    @(negedge clk);
    rst      = r;
    reqValid = v;
    rspReady = rr;
    for (int i = 0; i < NREQ; i++) begin
      reqA[16*i +: 16] = opA[i];
      reqB[16*i +: 16] = opB[i];
    end
    #1;
  endtask

  // Compare against the model, then advance the model across the next edge.
  // With at most two operations in flight, the oldest one is visible on the
  // response port from the second edge after its accept onward.
  task automatic checkOutput();
    logic [NREQ-1:0] expReady;
    logic            expRv;
    int              fv;
    entry_t          e;
    expReady = '0;
    fv = -1;
    if (!rst) begin
      fv = firstValid(reqValid, modelPtr);
      if (fv >= 0 && (sbQ.size() < 2 || rspReady)) expReady[fv] = 1'b1;
    end
    check("req_ready", 32'(reqReady), 32'(expReady));
    expRv = (sbQ.size() > 0) && (edgeCount >= sbQ[0].acceptEdge + 1);
    check("rsp_valid", 32'(rspValid), 32'(expRv));
    if (expRv) begin
      check("rsp_id", 32'(rspId), 32'(sbQ[0].id));
      check("rsp_co_sum", 32'({rspCo, rspSum}), 32'(sbQ[0].res));
    end
    check("done_cnt", 32'(doneCnt), 32'(modelDone));
    edgeCount++;
    if (rst) begin
      sbQ.delete();
      modelPtr  = 0;
      modelDone = '0;
    end else begin
      if (expRv && rspReady) begin
        void'(sbQ.pop_front());
        modelDone = modelDone + 16'd1;
      end
      if (expReady != '0) begin
        e.id         = fv;
        e.res        = {1'b0, opA[fv]} + {1'b0, opB[fv]};
        e.acceptEdge = edgeCount;
        sbQ.push_back(e);
        modelPtr = (fv + 1) % NREQ;
      end
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic rr, input logic r);
    applyStimulus(v, rr, r);
    checkOutput();
  endtask

  vec_t vecs [7];
  logic [NREQ-1:0] prevValid, prevReady, nextValid;
  int   accepts;
  int   drained [$];
  logic [15:0] doneBase;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    edgeCount   = 0;
    modelPtr    = 0;
    modelDone   = '0;
    rst         = 1'b1;
    reqValid    = '0;
    rspReady    = 1'b0;
    reqA        = '0;
    reqB        = '0;
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0;
      opB[i] = '0;
    end

    vecs[0] = '{2, 16'h1234, 16'h0FF1, 16'h2225, 1'b0};
    vecs[1] = '{0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[2] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
    vecs[3] = '{3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
    vecs[4] = '{2, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
    vecs[5] = '{1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
    vecs[6] = '{3, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    repeat (2) @(posedge clk);
    applyStimulus('0, 1'b1, 1'b1);
    check("reset_rsp_sum", 32'(rspSum), 32'h0);
    check("reset_rsp_co", 32'(rspCo), 32'h0);
    check("reset_rsp_id", 32'(rspId), 32'h0);
    checkOutput();

    // Directed single operations: accept, one cycle in flight, then response.
    doneBase = modelDone;
    for (int n = 0; n < 7; n++) begin
      opA[vecs[n].id] = vecs[n].a;
      opB[vecs[n].id] = vecs[n].b;
      applyStimulus(NREQ'(1) << vecs[n].id, 1'b1, 1'b0);
      check("vec_ready", 32'(reqReady), 32'(NREQ'(1) << vecs[n].id));
      check("vec_done_cnt", 32'(doneCnt), 32'(doneBase) + 32'(n));
      checkOutput();
      cycle('0, 1'b1, 1'b0);
      applyStimulus('0, 1'b1, 1'b0);
      check("vec_rsp_valid", 32'(rspValid), 32'h1);
      check("vec_rsp_id", 32'(rspId), 32'(vecs[n].id));
      check("vec_rsp_sum", 32'(rspSum), 32'(vecs[n].sum));
      check("vec_rsp_co", 32'(rspCo), 32'(vecs[n].co));
      checkOutput();
    end
    applyStimulus('0, 1'b1, 1'b0);
    check("vec_final_done", 32'(doneCnt), 32'(doneBase) + 32'd7);
    checkOutput();

    // Round-robin with all requesters held valid from reset.
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = 16'(16'h1000 * (i + 1));
      opB[i] = 16'(i + 7);
    end
    cycle('0, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      applyStimulus('1, 1'b1, 1'b0);
      check("rr_order", 32'(reqReady), 32'(NREQ'(1) << (c % NREQ)));
      if (c >= 2) begin
        check("rr_rsp_valid", 32'(rspValid), 32'h1);
        check("rr_rsp_id", 32'(rspId), 32'((c - 2) % NREQ));
      end
      checkOutput();
    end

    // Backpressure with requesters 1 and 3, then drain.
    cycle('0, 1'b1, 1'b1);
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1010, 1'b0, 1'b0);
      accepts += $countones(reqReady & reqValid);
      if (c == 4) check("bp_stalled_ready", 32'(reqReady), 32'h0);
      checkOutput();
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    drained.delete();
    for (int c = 0; c < 4; c++) begin
      applyStimulus('0, 1'b1, 1'b0);
      if (rspValid) drained.push_back(int'(rspId));
      checkOutput();
    end
    check("bp_drain_count", 32'(drained.size()), 32'd2);
    if (drained.size() == 2) begin
      check("bp_drain_first", 32'(drained[0]), 32'd1);
      check("bp_drain_second", 32'(drained[1]), 32'd3);
    end

    // Reset with both stages full.
    for (int c = 0; c < 3; c++) cycle('1, 1'b0, 1'b0);
    cycle('1, 1'b0, 1'b1);
    applyStimulus(4'b0110, 1'b1, 1'b0);
    check("rst_mid_rsp_valid", 32'(rspValid), 32'h0);
    check("rst_mid_done_cnt", 32'(doneCnt), 32'h0);
    check("rst_mid_grant", 32'(reqReady), 32'(4'b0010));
    checkOutput();

    // Random soak; a requester that is still waiting keeps its operands.
    prevValid = '0;
    prevReady = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (prevValid[i] && !prevReady[i]) begin
          nextValid[i] = 1'b1;
        end else begin
          nextValid[i] = ($urandom_range(0, 99) < 60);
          opA[i] = 16'($urandom);
          opB[i] = 16'($urandom);
        end
      end
      applyStimulus(nextValid, ($urandom_range(0, 99) < 70), 1'b0);
      prevValid = reqValid;
      prevReady = reqReady;
      checkOutput();
    end
    for (int c = 0; c < 4; c++) cycle('0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
